// File: rtl/mc_main_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_main_fsm_if
// Brief    : Control bundle between the multicycle main FSM and the datapath.
//            master = control FSM side, slave = datapath side.
// Revision : 1.0  initial release
// ============================================================================
interface mc_main_fsm_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcen;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, aluop, pcen, illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, aluop, pcen, illegal_op, state
    );
endinterface
`default_nettype wire

// File: rtl/mc_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_main_fsm
// Brief    : Main control FSM of the multicycle MIPS-subset processor.
//            Sequences fetch/decode/execute/memory/writeback and drives the
//            datapath enables and mux selects (Moore, plus ready-qualified
//            fetch strobes and the illegal-opcode pulse).
// Revision : 1.0  initial release
// ============================================================================
module mc_main_fsm #(
    parameter int MEM_WAIT_EN = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mc_main_fsm_if.master bus
);
    localparam logic [3:0] C_FETCH   = 4'd0;
    localparam logic [3:0] C_DECODE  = 4'd1;
    localparam logic [3:0] C_MEMADR  = 4'd2;
    localparam logic [3:0] C_MEMRD   = 4'd3;
    localparam logic [3:0] C_MEMWB   = 4'd4;
    localparam logic [3:0] C_MEMWR   = 4'd5;
    localparam logic [3:0] C_EXECUTE = 4'd6;
    localparam logic [3:0] C_ALUWB   = 4'd7;
    localparam logic [3:0] C_BRANCH  = 4'd8;
    localparam logic [3:0] C_ADDIEX  = 4'd9;
    localparam logic [3:0] C_ADDIWB  = 4'd10;
    localparam logic [3:0] C_JUMP    = 4'd11;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       w_ready;
    logic       w_illegal;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [1:0] w_aluop;

    // With waits disabled the memory is assumed to always complete in one cycle
    assign w_ready = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

    // Next-state selection; illegal opcodes bail out to FETCH from DECODE
    always_comb begin
        state_d   = state_q;
        w_illegal = 1'b0;
        case (state_q)
            C_FETCH:   if (w_ready) state_d = C_DECODE;
            C_DECODE: begin
                case (bus.op)
                    C_OP_LW, C_OP_SW: state_d = C_MEMADR;
                    C_OP_RTYPE:       state_d = C_EXECUTE;
                    C_OP_BEQ:         state_d = C_BRANCH;
                    C_OP_ADDI:        state_d = C_ADDIEX;
                    C_OP_J:           state_d = C_JUMP;
                    default: begin
                        state_d   = C_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            // IR is stable here, so the live opcode picks load vs store
            C_MEMADR:  state_d = (bus.op == C_OP_SW) ? C_MEMWR : C_MEMRD;
            C_MEMRD:   if (w_ready) state_d = C_MEMWB;
            C_MEMWR:   if (w_ready) state_d = C_FETCH;
            C_EXECUTE: state_d = C_ALUWB;
            C_ADDIEX:  state_d = C_ADDIWB;
            default:   state_d = C_FETCH;
        endcase
    end

    // State register; reset overrides every transition
    always_ff @(posedge clk) begin
        if (reset) state_q <= C_FETCH;
        else       state_q <= state_d;
    end

    // Per-state control decode; anything not set for a state stays 0
    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_aluop    = 2'b00;
        case (state_q)
            C_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = w_ready;
                w_pcwrite = w_ready;
            end
            C_DECODE:  w_alusrcb = 2'b11;
            C_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            C_MEMRD:   w_iord = 1'b1;
            C_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            C_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            C_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            C_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            C_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            C_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            C_ADDIWB:  w_regwrite = 1'b1;
            C_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // State-changing strobes are suppressed while reset is held
    assign bus.regwrite   = w_regwrite & ~reset;
    assign bus.memwrite   = w_memwrite & ~reset;
    assign bus.irwrite    = w_irwrite  & ~reset;
    assign bus.pcen       = (w_pcwrite | (w_branch & bus.zero)) & ~reset;
    assign bus.illegal_op = w_illegal  & ~reset;
    assign bus.iord       = w_iord;
    assign bus.regdst     = w_regdst;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.aluop      = w_aluop;
    assign bus.state      = state_q;
endmodule
`default_nettype wire

// File: tb/tb_mc_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_main_fsm
// Brief    : Directed table-driven bench for mc_main_fsm, plus hand-written
//            sequences for the illegal-op pulse width and MEM_WAIT_EN=0.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_main_fsm;
    // Control word layout:
    // {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    //  alusrcb[1:0], pcsrc[1:0], aluop[1:0], pcen, illegal_op}
    localparam logic [14:0] C_FETCH_RDY = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
    localparam logic [14:0] C_FETCH_WT  = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [14:0] C_FETCH_RST = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [14:0] C_DEC       = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [14:0] C_DEC_ILL   = 15'b0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [14:0] C_MEMADR    = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [14:0] C_MEMRD     = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] C_MEMWB     = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [14:0] C_MEMWR     = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] C_MEMWR_RST = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] C_EXEC      = 15'b0_0_0_0_0_0_1_00_00_10_0_0;
    localparam logic [14:0] C_ALUWB     = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [14:0] C_ALUWB_RST = 15'b0_0_0_1_0_0_0_00_00_00_0_0;
    localparam logic [14:0] C_BR_Z1     = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [14:0] C_BR_Z0     = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [14:0] C_ADDIEX    = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [14:0] C_ADDIWB    = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [14:0] C_JUMP      = 15'b0_0_0_0_0_0_0_00_10_00_1_0;

    localparam logic [5:0] C_R    = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_ADDI = 6'b001000;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_BAD  = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  exp_state;
        logic [14:0] exp_ctl;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    mc_main_fsm_if bus  ();
    mc_main_fsm_if bus0 ();

    mc_main_fsm #(.MEM_WAIT_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Second instance with waits disabled: mem_ready is tied low throughout
    mc_main_fsm #(.MEM_WAIT_EN(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );
    assign bus0.op        = C_R;
    assign bus0.zero      = 1'b0;
    assign bus0.mem_ready = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ctl_word();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop,
                bus.pcen, bus.illegal_op};
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %b required %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [5:0] op, input logic zero,
                       input logic rdy, input logic [3:0] st, input logic [14:0] ctl);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = zero; v.rdy = rdy;
        v.exp_state = st; v.exp_ctl = ctl;
        vecs.push_back(v);
    endtask

    initial begin
        int ill_cnt;
        logic [3:0] exp0 [5];
        n_checks = 0;
        n_errors = 0;

        // R-type: 0,1,6,7
        add(1, C_R,    0, 1,  0, C_FETCH_RST);
        add(0, C_R,    0, 1,  0, C_FETCH_RDY);
        add(0, C_R,    0, 1,  1, C_DEC);
        add(0, C_R,    0, 1,  6, C_EXEC);
        add(0, C_R,    0, 1,  7, C_ALUWB);
        // lw: two fetch waits, one MEMRD wait
        add(0, C_LW,   0, 0,  0, C_FETCH_WT);
        add(0, C_LW,   0, 0,  0, C_FETCH_WT);
        add(0, C_LW,   0, 1,  0, C_FETCH_RDY);
        add(0, C_LW,   0, 1,  1, C_DEC);
        add(0, C_LW,   0, 1,  2, C_MEMADR);
        add(0, C_LW,   0, 0,  3, C_MEMRD);
        add(0, C_LW,   0, 1,  3, C_MEMRD);
        add(0, C_LW,   0, 1,  4, C_MEMWB);
        // sw: three MEMWR waits, memwrite held for all four cycles
        add(0, C_SW,   0, 1,  0, C_FETCH_RDY);
        add(0, C_SW,   0, 1,  1, C_DEC);
        add(0, C_SW,   0, 1,  2, C_MEMADR);
        add(0, C_SW,   0, 0,  5, C_MEMWR);
        add(0, C_SW,   0, 0,  5, C_MEMWR);
        add(0, C_SW,   0, 0,  5, C_MEMWR);
        add(0, C_SW,   0, 1,  5, C_MEMWR);
        // beq taken then not taken
        add(0, C_BEQ,  1, 1,  0, C_FETCH_RDY);
        add(0, C_BEQ,  1, 1,  1, C_DEC);
        add(0, C_BEQ,  1, 1,  8, C_BR_Z1);
        add(0, C_BEQ,  0, 1,  0, C_FETCH_RDY);
        add(0, C_BEQ,  0, 1,  1, C_DEC);
        add(0, C_BEQ,  0, 1,  8, C_BR_Z0);
        // addi, j, illegal
        add(0, C_ADDI, 0, 1,  0, C_FETCH_RDY);
        add(0, C_ADDI, 0, 1,  1, C_DEC);
        add(0, C_ADDI, 0, 1,  9, C_ADDIEX);
        add(0, C_ADDI, 0, 1, 10, C_ADDIWB);
        add(0, C_J,    0, 1,  0, C_FETCH_RDY);
        add(0, C_J,    0, 1,  1, C_DEC);
        add(0, C_J,    0, 1, 11, C_JUMP);
        add(0, C_BAD,  0, 1,  0, C_FETCH_RDY);
        add(0, C_BAD,  0, 1,  1, C_DEC_ILL);
        add(0, C_BAD,  0, 0,  0, C_FETCH_WT);
        // reset during MEMWR wait, then held reset
        add(0, C_SW,   0, 1,  0, C_FETCH_RDY);
        add(0, C_SW,   0, 1,  1, C_DEC);
        add(0, C_SW,   0, 1,  2, C_MEMADR);
        add(0, C_SW,   0, 0,  5, C_MEMWR);
        add(1, C_SW,   0, 0,  5, C_MEMWR_RST);
        add(1, C_SW,   0, 1,  0, C_FETCH_RST);
        add(1, C_SW,   0, 1,  0, C_FETCH_RST);
        // reset during ALUWB: no register write on that cycle
        add(0, C_R,    0, 1,  0, C_FETCH_RDY);
        add(0, C_R,    0, 1,  1, C_DEC);
        add(0, C_R,    0, 1,  6, C_EXEC);
        add(1, C_R,    0, 1,  7, C_ALUWB_RST);
        add(0, C_R,    0, 0,  0, C_FETCH_WT);

        reset         = 1'b1;
        bus.op        = C_R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            #2;
            reset         = vecs[i].rst;
            bus.op        = vecs[i].op;
            bus.zero      = vecs[i].zero;
            bus.mem_ready = vecs[i].rdy;
            #1;
            check("state", i, {11'd0, bus.state}, {11'd0, vecs[i].exp_state});
            check("ctl",   i, ctl_word(), vecs[i].exp_ctl);
            @(posedge clk);
        end

        // Illegal opcode: exactly one pulse, FSM parks in FETCH afterwards
        ill_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            #2;
            bus.op        = 6'b010101;
            bus.mem_ready = (k == 0);
            #1;
            if (bus.illegal_op) ill_cnt++;
            @(posedge clk);
        end
        #3;
        check("ill_pulses", 0, 15'(ill_cnt), 15'd1);
        check("ill_state",  0, {11'd0, bus.state}, 15'd0);

        // MEM_WAIT_EN=0 instance runs R-type with mem_ready stuck low
        exp0[0] = 4'd0; exp0[1] = 4'd1; exp0[2] = 4'd6; exp0[3] = 4'd7; exp0[4] = 4'd0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("nowait_state", k, {11'd0, bus0.state}, {11'd0, exp0[k]});
            if (k == 0) check("nowait_irwrite", k, {14'd0, bus0.irwrite}, 15'd1);
            @(posedge clk);
            #2;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
- Main control state machine for the 32-bit non-pipelined (multicycle) MIPS-subset processor.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath enables and muxes.
- Produces the 2-bit aluop code consumed by the ALU function decoder (00 add, 01 sub, 10 use funct).

Parameters:
- MEM_WAIT_EN, 1, when 1 FETCH/MEMRD/MEMWR hold until mem_ready=1; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; state forced to FETCH on the next rising edge
- op  input  6  instr[31:26] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete this cycle
- iord  output  1  memory address select (0 PC, 1 ALUOut)
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register load
- regdst  output  1  write register select (0 rt, 1 rd)
- memtoreg  output  1  writeback select (0 ALUOut, 1 data reg)
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select (0 PC, 1 regA)
- alusrcb  output  2  ALU B select (00 regB, 01 const 4, 10 signimm, 11 signimm<<2)
- pcsrc  output  2  next PC select (00 ALUResult, 01 ALUOut, 10 jump target)
- aluop  output  2  to ALU decoder (00 add, 01 sub, 10 funct)
- pcen  output  1  PC register enable
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- state  output  4  current state encoding, for debug and bench

Behaviour:
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010. All others are illegal.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable; if entered, go to FETCH.
- Moore outputs decode from the state register. Any output not listed for a state is 0.
- pcen = pcwrite | (branch & zero), where pcwrite and branch are internal.
- Per-state outputs:
  - FETCH: alusrcb=01. irwrite=1 and pcwrite=1 only when mem_ready (or MEM_WAIT_EN=0).
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1. memwrite stays high for every wait cycle.
  - EXECUTE: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH: to DECODE when ready, else hold.
  - DECODE by op: lw/sw go to MEMADR; R-type to EXECUTE; beq to BRANCH; addi to ADDIEX; j to JUMP. Illegal opcode: go to FETCH and pulse illegal_op for exactly that DECODE cycle (combinational from state plus op).
  - MEMADR: lw goes to MEMRD, sw goes to MEMWR (op sampled live; IR is stable).
  - MEMRD: to MEMWB when ready, else hold.
  - MEMWR: to FETCH when ready, else hold.
  - EXECUTE to ALUWB; ADDIEX to ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Reset:
  - While reset=1, regwrite, memwrite, irwrite, pcen and illegal_op are forced to 0 regardless of state.
  - reset=1 at an edge makes state=0 after that edge. Other outputs follow the FETCH decode.
  - Reset mid-instruction abandons it with no partial write after the edge.
  - Reset has priority over mem_ready and over all transitions.
- aluop never takes the value 11.

Test Plan:
- Reset then R-type (op=000000), mem_ready=1 -> state 0,1,6,7,0. aluop=10 in state 6. regwrite=1 and regdst=1 only in state 7.
- lw (100011) with mem_ready=0 for 2 cycles in FETCH and 1 in MEMRD -> state 0,0,0,1,2,3,3,4,0. irwrite/pcen high only on the third FETCH cycle. memtoreg=regwrite=1 in state 4.
- sw (101011) with 3 wait cycles in MEMWR -> memwrite=1 and iord=1 for 4 consecutive cycles in state 5, then state 0. regwrite is never 1.
- beq (000100) with zero=1, then a second beq with zero=0 -> state 0,1,8,0. In state 8: aluop=01, pcsrc=01, pcen=1 only for the zero=1 case.
- addi (001000), then j (000010), then op=111111 -> addi gives 0,1,9,10,0 with alusrcb=10. j gives pcsrc=10, pcen=1 in state 11. Illegal op gives illegal_op=1 for one cycle in state 1, then state 0.
- Assert reset during MEMWR wait -> memwrite=0 in that same cycle, state=0 after the edge. Held reset keeps pcen=irwrite=0.
